// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM output stage.
// The configuration struct bundles every register-file field that the
// output stage consumes, so it can be carried through the sync filter as one word.
package pwm_pkg;

    localparam int         PWM_CNT_W = 8;
    localparam logic [7:0] PWM_FULL  = 8'hFF;

    typedef struct packed {
        logic [7:0]           en_out_uo;
        logic [7:0]           en_out_uio;
        logic [7:0]           en_pwm_uo;
        logic [7:0]           en_pwm_uio;
        logic [PWM_CNT_W-1:0] duty;
    } pwm_cfg_t;

    // Per-bit pad selection: disabled bits are 0, enabled bits follow the
    // PWM level when PWM-selected and are held high otherwise.
    function automatic logic [7:0] pad_mux(input logic [7:0] en_out,
                                           input logic [7:0] en_pwm,
                                           input logic       level);
        return en_out & (~en_pwm | {8{level}});
    endfunction

endpackage

// File: rtl/pwm_cfg_sync.sv
// Configuration hand-off from the SPI-written registers into the clk domain.
// Build option PWM_CFG_SYNC_EN: when defined, every config bit passes through
// three flops and cfg_q only takes a value that has been seen identically on two
// consecutive clocks, so single-cycle glitches never reach the pads.
// When undefined, the registers are assumed to share clk and pass straight through.
module pwm_cfg_sync
    import pwm_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  pwm_cfg_t cfg_in,
    output pwm_cfg_t cfg_q
);

`ifdef PWM_CFG_SYNC_EN
    pwm_cfg_t s1;
    pwm_cfg_t s2;
    pwm_cfg_t s3;

    // Three-stage synchronizer with a two-sample stability gate on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            cfg_q <= '0;
        end else begin
            s1 <= cfg_in;
            s2 <= s1;
            s3 <= s2;
            if (s2 == s3) begin
                cfg_q <= s2;
            end
        end
    end
`else
    // Clock and reset are only needed by the filtered build; the name keeps
    // them visibly consumed in this configuration.
    logic sync_unused;
    assign sync_unused = clk & rst_n;

    assign cfg_q = cfg_in;
`endif

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaled free-running 8-bit PWM with a per-period duty
// shadow, and per-bit enable/PWM-select muxing onto uo_out/uio_out/uio_oe.
// Build option PWM_CFG_SYNC_EN selects the filtered config path in pwm_cfg_sync.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13,
    parameter int CNT_W    = PWM_CNT_W
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_out_uo,
    input  logic [7:0] en_out_uio,
    input  logic [7:0] en_pwm_uo,
    input  logic [7:0] en_pwm_uio,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    pwm_cfg_t         cfg_in;
    pwm_cfg_t         cfg_q;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_q;
    logic             wrap;
    logic             pwm_level;

    // Gather the register-file fields into one config word.
    always_comb begin
        cfg_in            = '0;
        cfg_in.en_out_uo  = en_out_uo;
        cfg_in.en_out_uio = en_out_uio;
        cfg_in.en_pwm_uo  = en_pwm_uo;
        cfg_in.en_pwm_uio = en_pwm_uio;
        cfg_in.duty       = pwm_duty_cycle;
    end

    pwm_cfg_sync u_cfg_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_in (cfg_in),
        .cfg_q  (cfg_q)
    );

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign wrap      = tick && (pwm_cnt == {CNT_W{1'b1}});
    assign pwm_level = (duty_q == PWM_FULL) ? 1'b1 : (pwm_cnt < duty_q);

    // Prescaler divides clk down to one PWM counter tick every PRESCALE clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // PWM counter, wrap pulse, and duty shadow loaded only at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_q       <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (wrap) begin
                duty_q <= cfg_q.duty;
            end
        end
    end

    // Registered pad drivers so the pins never see combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else begin
            uo_out  <= pad_mux(cfg_q.en_out_uo, cfg_q.en_pwm_uo, pwm_level);
            uio_out <= pad_mux(cfg_q.en_out_uio, cfg_q.en_pwm_uio, pwm_level);
            uio_oe  <= cfg_q.en_out_uio;
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Testbench for pwm_output_stage with PRESCALE=2 (512-clk period).
// The reference model tracks time as clock edges since reset release and
// derives counter position, period index and duty from plain arithmetic.
module tb_pwm_output_stage;

    localparam int P   = 2;
    localparam int PER = 256 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] en_out_uo = '0;
    logic [7:0] en_out_uio = '0;
    logic [7:0] en_pwm_uo = '0;
    logic [7:0] en_pwm_uio = '0;
    logic [7:0] pwm_duty_cycle = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       period_start;

    int         errors = 0;
    int         checks = 0;
    int         n = 0;
    int         settle = 0;
    logic [7:0] modelDuty = '0;

    pwm_output_stage #(.PRESCALE(P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_out_uo      (en_out_uo),
        .en_out_uio     (en_out_uio),
        .en_pwm_uo      (en_pwm_uo),
        .en_pwm_uio     (en_pwm_uio),
        .pwm_duty_cycle (pwm_duty_cycle),
        .uo_out         (uo_out),
        .uio_out        (uio_out),
        .uio_oe         (uio_oe),
        .period_start   (period_start)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Spec rule for one pad bank, evaluated bit by bit.
    function automatic logic [7:0] expectPads(input logic [7:0] enOut, input logic [7:0] enPwm, input logic lvl);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (!enOut[i])      r[i] = 1'b0;
            else if (enPwm[i])  r[i] = lvl;
            else                r[i] = 1'b1;
        end
        return r;
    endfunction

    // Advance one clock, update the model, and compare everything that is settled.
    task automatic stepClk();
        int         cnt;
        logic [7:0] d;
        logic       lvl;
        @(posedge clk);
        #1;
        n++;
        cnt = ((n - 1) / P) % 256;
        d   = modelDuty;
        if (n % PER == 0) modelDuty = pwm_duty_cycle;
        lvl = (d == 8'hFF) ? 1'b1 : (cnt < int'(d));
        settle++;
        checkOutput("period_start", period_start, (n % PER == 0));
        if (settle >= 6) begin
            checkOutput("uo_out",  uo_out,  expectPads(en_out_uo,  en_pwm_uo,  lvl));
            checkOutput("uio_out", uio_out, expectPads(en_out_uio, en_pwm_uio, lvl));
            checkOutput("uio_oe",  uio_oe,  en_out_uio);
        end
    endtask

    task automatic runCycles(input int k);
        for (int i = 0; i < k; i++) stepClk();
    endtask

    // Step until the period phase reaches ph (at least one step, bounded).
    task automatic waitPhase(input int ph);
        int guard = 0;
        do begin
            stepClk();
            guard++;
        end while ((n % PER != ph) && (guard <= PER));
        checkOutput("wait_phase", n % PER, ph);
    endtask

    task automatic applyStimulus(input logic [7:0] eoUo, input logic [7:0] eoUio,
                                 input logic [7:0] epUo, input logic [7:0] epUio,
                                 input logic [7:0] duty);
        if ({eoUo, eoUio, epUo, epUio} != {en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio})
            settle = 0;
        en_out_uo      = eoUo;
        en_out_uio     = eoUio;
        en_pwm_uo      = epUo;
        en_pwm_uio     = epUio;
        pwm_duty_cycle = duty;
    endtask

    // Count uo_out[0] high samples over one full period starting now.
    task automatic countHigh(input int steps, output int highs, output int firstHigh);
        highs = 0;
        firstHigh = -1;
        for (int i = 1; i <= steps; i++) begin
            stepClk();
            if (uo_out[0]) begin
                highs++;
                if (firstHigh < 0) firstHigh = i;
            end
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n     = 1'b1;
        n         = 0;
        settle    = 0;
        modelDuty = '0;
    endtask

    initial begin
        int highs, firstHigh, h2, f2;

        // Reset state
        #3;
        checkOutput("rst_uo",  uo_out, 8'h00);
        checkOutput("rst_uio", uio_out, 8'h00);
        checkOutput("rst_oe",  uio_oe, 8'h00);
        checkOutput("rst_ps",  period_start, 1'b0);
        releaseReset();

        // 1: static-high outputs
        applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        runCycles(20);
        checkOutput("t1_uo", uo_out, 8'hFF);
        checkOutput("t1_oe", uio_oe, 8'h00);

        // 2: 50% duty on bit 0
        applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h80);
        waitPhase(0);
        checkOutput("t2_ps", period_start, 1'b1);
        countHigh(PER, highs, firstHigh);
        checkOutput("t2_high", highs, 256);
        checkOutput("t2_rise", firstHigh, 1);
        checkOutput("t2_upper", uo_out[7:1], 7'h00);

        // 3: duty extremes
        applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h00);
        waitPhase(0);
        countHigh(PER, highs, firstHigh);
        checkOutput("t3_zero", highs, 0);
        applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'hFF);
        waitPhase(0);
        countHigh(PER, highs, firstHigh);
        checkOutput("t3_full", highs, PER);

        // 4: mid-period duty write waits for the next period
        applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h40);
        waitPhase(0);
        countHigh(200, highs, firstHigh);
        applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'hC0);
        countHigh(PER - 200, h2, f2);
        checkOutput("t4_cur", highs + h2, 128);
        countHigh(PER, highs, firstHigh);
        checkOutput("t4_next", highs, 384);

        // 5: uio bank static with output enables
        applyStimulus(8'h00, 8'hA5, 8'h00, 8'h00, 8'hC0);
        runCycles(10);
        checkOutput("t5_oe",  uio_oe, 8'hA5);
        checkOutput("t5_uio", uio_out, 8'hA5);
`ifdef PWM_CFG_SYNC_EN
        en_out_uio = 8'hFF;
        stepClk();
        en_out_uio = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            stepClk();
            checkOutput("t5_glitch", uio_oe, 8'hA5);
        end
`endif

        // Randomized configuration changes away from the period boundary
        for (int i = 0; i < 8 * PER; i++) begin
            if ((n % PER) >= 20 && (n % PER) <= 480 && $urandom_range(63) == 0)
                applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                              8'($urandom), 8'($urandom));
            stepClk();
        end

        // 6: asynchronous reset mid-period with outputs high
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        waitPhase(0);
        waitPhase(75);
        checkOutput("t6_pre", uo_out, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_uo",  uo_out, 8'h00);
        checkOutput("t6_uio", uio_out, 8'h00);
        checkOutput("t6_oe",  uio_oe, 8'h00);
        checkOutput("t6_ps",  period_start, 1'b0);
        releaseReset();
        runCycles(PER - 1);
        checkOutput("t6_no_early", period_start, 1'b0);
        stepClk();
        checkOutput("t6_first_ps", period_start, 1'b1);
        runCycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
